// File: rtl/tsm_xor_scheduler.sv
// tsm_xor_scheduler
// Time-shares one WIDTH-bit XOR unit across the SHARES shares of two masked
// operands. The XOR unit sees one share index per slot, and zero-precharge gap
// cycles separate slots. Each result share is returned on a valid/ready stream
// together with its index and a last flag.
module tsm_xor_scheduler #(
    parameter int WIDTH  = 8,
    parameter int SHARES = 2,
    parameter int GAP    = 1,
    localparam int IDXW  = (SHARES > 1) ? $clog2(SHARES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SHARES*WIDTH-1:0] a_shares,
    input  logic [SHARES*WIDTH-1:0] b_shares,
    output logic [WIDTH-1:0]        xor_a,
    output logic [WIDTH-1:0]        xor_b,
    input  logic [WIDTH-1:0]        xor_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_share,
    output logic [IDXW-1:0]         out_idx,
    output logic                    out_last,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SHARES - 1);
    // Gap counter preset: counts down to 0 on the final gap cycle.
    localparam logic [1:0]      GAP_INIT = 2'((GAP > 0) ? GAP - 1 : 0);

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic [IDXW-1:0]   idx_next;
    logic [1:0]        gap_cnt;
    logic              is_last;

    // Share registers: hold the not-yet-issued shares of the current pair.
    logic [WIDTH-1:0]  a_reg [SHARES];
    logic [WIDTH-1:0]  b_reg [SHARES];

    assign idx_next = idx + IDXW'(1);
    assign is_last  = (idx == LAST_IDX);

    // Handshake and status flags are decoded straight from the state register.
    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Slot sequencer: operand issue, result capture, precharge gaps, zeroization.
    // NOTE: every sequential assignment is non-blocking so all registers update
    // from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            xor_a     <= '0;
            xor_b     <= '0;
            out_share <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            // NOTE: the share array is reset explicitly (not left to power-up)
            // because an aborted transaction must not leave secret shares behind.
            for (int i = 0; i < SHARES; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < SHARES; i++) begin
                            a_reg[i] <= a_shares[i*WIDTH +: WIDTH];
                            b_reg[i] <= b_shares[i*WIDTH +: WIDTH];
                        end
                        // Share 0 goes onto the XOR unit on entry to ISSUE.
                        xor_a <= a_shares[WIDTH-1:0];
                        xor_b <= b_shares[WIDTH-1:0];
                        idx   <= '0;
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    out_share <= xor_y;
                    out_idx   <= idx;
                    out_last  <= is_last;
                    out_valid <= 1'b1;
                    // The consumed shares are wiped as soon as they are used.
                    a_reg[idx] <= '0;
                    b_reg[idx] <= '0;
                    // With gaps configured, precharge starts right away. With no
                    // gaps the operands stay put until the next share replaces
                    // them, except after the final share.
                    if ((GAP != 0) || is_last) begin
                        xor_a <= '0;
                        xor_b <= '0;
                    end
                    state <= S_HOLD;
                end

                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (is_last) begin
                            idx   <= '0;
                            state <= S_IDLE;
                        end else if (GAP == 0) begin
                            xor_a <= a_reg[idx_next];
                            xor_b <= b_reg[idx_next];
                            idx   <= idx_next;
                            state <= S_ISSUE;
                        end else begin
                            gap_cnt <= GAP_INIT;
                            state   <= S_GAP;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt == 2'd0) begin
                        xor_a <= a_reg[idx_next];
                        xor_b <= b_reg[idx_next];
                        idx   <= idx_next;
                        state <= S_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - 2'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tsm_xor_scheduler.sv
// tb_tsm_xor_scheduler
// Three scheduler instances (SHARES/GAP = 2/1, 3/0, 4/3) on one clock. A
// slot-timeline model predicts every output each cycle. Directed sequences add
// hand-computed literal expectations, latency checks and recombination checks.
module tb_tsm_xor_scheduler;

    localparam int W  = 8;
    localparam int NI = 3;

    function automatic int shares_of(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int gap_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         chk_en;
    int           cyc = 0;

    logic         in_valid  [NI];
    logic         out_ready [NI];
    logic [4*W-1:0] a_in    [NI];
    logic [4*W-1:0] b_in    [NI];
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic         out_last  [NI];
    logic         busy      [NI];
    logic [W-1:0] xa        [NI];
    logic [W-1:0] xb        [NI];
    logic [W-1:0] out_share [NI];
    logic [2:0]   out_idx   [NI];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int S  = shares_of(k);
        localparam int G  = gap_of(k);
        localparam int IW = $clog2(S);
        logic [IW-1:0] idx_w;
        logic [W-1:0]  xa_w, xb_w;

        tsm_xor_scheduler #(.WIDTH(W), .SHARES(S), .GAP(G)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .a_shares  (a_in[k][S*W-1:0]),
            .b_shares  (b_in[k][S*W-1:0]),
            .xor_a     (xa_w),
            .xor_b     (xb_w),
            .xor_y     (xa_w ^ xb_w),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_share (out_share[k]),
            .out_idx   (idx_w),
            .out_last  (out_last[k]),
            .busy      (busy[k])
        );

        assign xa[k]      = xa_w;
        assign xb[k]      = xb_w;
        assign out_idx[k] = 3'(idx_w);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- slot-timeline model ----------------
    // Per instance: is a transaction open, which share is current, the cycle in
    // which that share sits on the XOR unit, and whether its result is offered.
    bit           m_busy    [NI];
    bit           m_valid   [NI];
    int           m_i       [NI];
    int           m_issue_t [NI];
    logic [W-1:0] m_a       [NI][4];
    logic [W-1:0] m_b       [NI][4];

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_busy[k]  = 0;
            m_valid[k] = 0;
            m_i[k]     = 0;
            m_issue_t[k] = -1;
        end
    end

    // Compare every cycle, then advance the model by one clock edge.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int s;
            int g;
            s = shares_of(k);
            g = gap_of(k);
            if (chk_en) begin
                check($sformatf("u%0d in_ready", k), 32'(in_ready[k]), 32'(!m_busy[k]));
                check($sformatf("u%0d busy", k), 32'(busy[k]), 32'(m_busy[k]));
                check($sformatf("u%0d out_valid", k), 32'(out_valid[k]), 32'(m_valid[k]));
                if (m_valid[k]) begin
                    check($sformatf("u%0d out_share", k), 32'(out_share[k]),
                          32'(m_a[k][m_i[k]] ^ m_b[k][m_i[k]]));
                    check($sformatf("u%0d out_idx", k), 32'(out_idx[k]), 32'(m_i[k]));
                    check($sformatf("u%0d out_last", k), 32'(out_last[k]), 32'(m_i[k] == s - 1));
                end
                if (m_busy[k] && cyc == m_issue_t[k]) begin
                    check($sformatf("u%0d xor_a issue", k), 32'(xa[k]), 32'(m_a[k][m_i[k]]));
                    check($sformatf("u%0d xor_b issue", k), 32'(xb[k]), 32'(m_b[k][m_i[k]]));
                end else if (!(g == 0 && m_valid[k])) begin
                    check($sformatf("u%0d xor_a precharge", k), 32'(xa[k]), 32'h0);
                    check($sformatf("u%0d xor_b precharge", k), 32'(xb[k]), 32'h0);
                end
            end
            if (!rst_n) begin
                m_busy[k]  = 0;
                m_valid[k] = 0;
            end else if (!m_busy[k]) begin
                if (in_valid[k]) begin
                    for (int i = 0; i < s; i++) begin
                        m_a[k][i] = a_in[k][i*W +: W];
                        m_b[k][i] = b_in[k][i*W +: W];
                    end
                    m_busy[k]    = 1;
                    m_i[k]       = 0;
                    m_issue_t[k] = cyc + 1;
                end
            end else if (cyc == m_issue_t[k]) begin
                m_valid[k] = 1;
            end else if (m_valid[k] && out_ready[k]) begin
                m_valid[k] = 0;
                if (m_i[k] == s - 1) begin
                    m_busy[k] = 0;
                end else begin
                    m_i[k]++;
                    m_issue_t[k] = cyc + 1 + g;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at #1 after a rising edge; returns at #1 after the edge that
    // follows the cycle in which in_ready was seen high.
    task automatic wait_idle(input int k);
        bit done;
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready[k]) done = 1;
            @(posedge clk); #1;
        end
        check($sformatf("u%0d idle within bound", k), 32'(done), 32'h1);
    endtask

    // One transaction with an optional out_ready=0 window, given in cycles
    // relative to the accept edge. Checks accept-to-in_ready latency and that
    // the XOR of all emitted shares equals the recombined A^B.
    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] b,
                       input int st_from, input int st_n, input int lit0);
        int s, g, n, exp_lat;
        bit done;
        logic [W-1:0] acc, ref_v;
        s = shares_of(k);
        g = gap_of(k);
        exp_lat = 1 + 2*s + (s-1)*g + st_n;
        @(posedge clk); #1;
        a_in[k] = a; b_in[k] = b; in_valid[k] = 1'b1; out_ready[k] = 1'b1;
        @(negedge clk);
        check($sformatf("u%0d ready before accept", k), 32'(in_ready[k]), 32'h1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        n = 1; acc = '0; done = 0;
        while (!done && n < 300) begin
            out_ready[k] = !(n >= st_from && n < st_from + st_n);
            @(negedge clk);
            if (in_ready[k]) begin
                done = 1;
            end else begin
                if (lit0 >= 0 && out_valid[k] && out_idx[k] == 3'd0)
                    check($sformatf("u%0d share0 literal", k), 32'(out_share[k]), 32'(lit0));
                if (out_valid[k] && out_ready[k]) acc ^= out_share[k];
                @(posedge clk); #1;
                n++;
            end
        end
        out_ready[k] = 1'b1;
        check($sformatf("u%0d latency", k), 32'(n), 32'(exp_lat));
        ref_v = '0;
        for (int i = 0; i < s; i++) ref_v ^= a[i*W +: W] ^ b[i*W +: W];
        check($sformatf("u%0d recombined", k), 32'(acc), 32'(ref_v));
    endtask

    // Watchdog in case the flow itself stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed flow ----------------
    initial begin
        logic [W-1:0] rec;
        rst_n  = 1'b0;
        chk_en = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1; a_in[k] = '0; b_in[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset state of every instance.
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("u%0d rst in_ready", k), 32'(in_ready[k]), 32'h1);
            check($sformatf("u%0d rst out_share", k), 32'(out_share[k]), 32'h0);
            check($sformatf("u%0d rst out_idx", k), 32'(out_idx[k]), 32'h0);
            check($sformatf("u%0d rst out_last", k), 32'(out_last[k]), 32'h0);
        end

        // Basic + precharge: A=3CA5, B=0F5A on the 2-share, 1-gap instance.
        @(posedge clk); #1;
        a_in[0] = 32'h3CA5; b_in[0] = 32'h0F5A; in_valid[0] = 1'b1;
        @(negedge clk);  // cycle 0
        check("basic c0 xor_a", 32'(xa[0]), 32'h0);
        check("basic c0 xor_b", 32'(xb[0]), 32'h0);
        @(posedge clk); #1 in_valid[0] = 1'b0;
        @(negedge clk);  // cycle 1
        check("basic c1 xor_a", 32'(xa[0]), 32'hA5);
        check("basic c1 xor_b", 32'(xb[0]), 32'h5A);
        @(negedge clk);  // cycle 2
        check("basic c2 out_valid", 32'(out_valid[0]), 32'h1);
        check("basic c2 share", 32'(out_share[0]), 32'hFF);
        check("basic c2 idx", 32'(out_idx[0]), 32'h0);
        check("basic c2 last", 32'(out_last[0]), 32'h0);
        check("basic a_reg0 wiped", 32'(g_dut[0].u_dut.a_reg[0]), 32'h0);
        check("basic b_reg0 wiped", 32'(g_dut[0].u_dut.b_reg[0]), 32'h0);
        rec = out_share[0];
        @(negedge clk);  // cycle 3
        check("basic c3 xor_a", 32'(xa[0]), 32'h0);
        check("basic c3 xor_b", 32'(xb[0]), 32'h0);
        @(negedge clk);  // cycle 4
        check("basic c4 xor_a", 32'(xa[0]), 32'h3C);
        check("basic c4 xor_b", 32'(xb[0]), 32'h0F);
        @(negedge clk);  // cycle 5
        check("basic c5 share", 32'(out_share[0]), 32'h33);
        check("basic c5 idx", 32'(out_idx[0]), 32'h1);
        check("basic c5 last", 32'(out_last[0]), 32'h1);
        check("basic c5 in_ready", 32'(in_ready[0]), 32'h0);
        rec ^= out_share[0];
        check("basic recombined", 32'(rec), 32'hCC);
        @(negedge clk);  // cycle 6
        check("basic c6 in_ready", 32'(in_ready[0]), 32'h1);

        // Backpressure: out_ready=0 for cycles 2..4 (share 0 held three cycles).
        txn(0, 32'h3CA5, 32'h0F5A, 2, 3, 8'hFF);

        // Back-to-back: in_valid held high, second pair presented while busy.
        @(posedge clk); #1;
        a_in[0] = 32'h3CA5; b_in[0] = 32'h0F5A; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        a_in[0] = 32'h1234; b_in[0] = 32'h00FF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("b2b c%0d in_ready", c), 32'(in_ready[0]), 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);  // cycle 6
        check("b2b c6 in_ready", 32'(in_ready[0]), 32'h1);
        check("b2b idle a_reg0", 32'(g_dut[0].u_dut.a_reg[0]), 32'h0);
        check("b2b idle a_reg1", 32'(g_dut[0].u_dut.a_reg[1]), 32'h0);
        check("b2b idle b_reg1", 32'(g_dut[0].u_dut.b_reg[1]), 32'h0);
        @(posedge clk); #1 in_valid[0] = 1'b0;
        @(negedge clk);  // cycle 7
        check("b2b c7 xor_a", 32'(xa[0]), 32'h34);
        check("b2b c7 xor_b", 32'(xb[0]), 32'hFF);
        @(posedge clk); #1;
        wait_idle(0);

        // Reset in the cycle-3 gap: the partial transaction is dropped.
        @(posedge clk); #1;
        a_in[0] = 32'h3CA5; b_in[0] = 32'h0F5A; in_valid[0] = 1'b1;
        @(posedge clk); #1 in_valid[0] = 1'b0;  // cycle 1
        @(posedge clk); #1;                     // cycle 2
        @(posedge clk); #1 rst_n = 1'b0;        // cycle 3
        @(posedge clk); #1 rst_n = 1'b1;        // cycle 4
        @(negedge clk);
        check("rst busy", 32'(busy[0]), 32'h0);
        check("rst out_valid", 32'(out_valid[0]), 32'h0);
        check("rst out_share", 32'(out_share[0]), 32'h0);
        check("rst out_idx", 32'(out_idx[0]), 32'h0);
        check("rst out_last", 32'(out_last[0]), 32'h0);
        check("rst xor_a", 32'(xa[0]), 32'h0);
        check("rst a_reg1 cleared", 32'(g_dut[0].u_dut.a_reg[1]), 32'h0);
        check("rst b_reg1 cleared", 32'(g_dut[0].u_dut.b_reg[1]), 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rst no share1", 32'(out_valid[0]), 32'h0);
        end
        txn(0, 32'h5A5A, 32'h0FF0, 0, 0, -1);

        // Config sweep: SHARES=3/GAP=0 and SHARES=4/GAP=3, random operands.
        for (int t = 0; t < 3; t++) begin
            txn(1, $urandom, $urandom, (t == 1) ? 2 : 0, (t == 1) ? 2 : 0, -1);
            txn(2, $urandom, $urandom, (t == 2) ? 7 : 0, (t == 2) ? 2 : 0, -1);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
